// File: rtl/cpu_cu_gen.sv
// cpu_cu_gen: multi-cycle FETCH/DECODE/EXECUTE control unit for the 301 CPU; define CU_MEM_WAIT_EN to stall memory states on mem_rdy
module cpu_cu_gen #(
   parameter int IR_W  = 16,
   parameter int RA_W  = 3,
   parameter int ALU_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IR_W-1:0]  IR,
   input  logic             N,
   input  logic             Z,
   input  logic             C,
   input  logic             mem_rdy,
   input  logic             cont,
   output logic [RA_W-1:0]  w_adr,
   output logic [RA_W-1:0]  r_adr,
   output logic [RA_W-1:0]  s_adr,
   output logic             adr_sel,
   output logic             s_sel,
   output logic             pc_ld,
   output logic             pc_inc,
   output logic             pc_sel,
   output logic             ir_ld,
   output logic             mw_en,
   output logic             rw_en,
   output logic [ALU_W-1:0] alu_op,
   output logic [7:0]       status,
   output logic             halted,
   output logic             illegal
);
   localparam int OPC_W = IR_W - 3*RA_W;
   // execute states are encoded by their status index so status is simply {flags, state}
   typedef enum logic [4:0] {
      S_ADD = 5'h00, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC,
      S_LOAD, S_STO, S_LDI, S_HALT, S_JE, S_JNE, S_JC, S_JMP,
      S_AND, S_OR, S_XOR, S_JN, S_JNN, S_JNC,
      S_RESET = 5'h1C, S_FETCH, S_DECODE, S_ILL
   } state_t;
   state_t           state_q, state_d, dec;
   logic [2:0]       flg_q, flg_d;
   logic [OPC_W-1:0] opc;
   logic [RA_W-1:0]  d, a, b;
   logic             rdy, legal, alu_st, in_exec;
   assign opc     = IR[IR_W-1:3*RA_W];
   assign d       = IR[3*RA_W-1:2*RA_W];
   assign a       = IR[2*RA_W-1:RA_W];
   assign b       = IR[RA_W-1:0];
   assign legal   = (opc >> 5) == ({OPC_W{1'b1}} >> 5);
   assign in_exec = state_q <= S_JNC;
   assign alu_st  = state_q inside {S_ADD, S_SUB, S_CMP, S_SHL, S_SHR, S_INC, S_DEC, S_AND, S_OR, S_XOR};
`ifdef CU_MEM_WAIT_EN
   assign rdy = mem_rdy;
`else
   logic unused_mem_rdy;
   assign unused_mem_rdy = mem_rdy;
   assign rdy = 1'b1;
`endif
   // opcode to execute state; upper half maps straight onto the index
   always_comb begin
      dec = S_ILL;
      if (legal)
         dec = opc[4] ? state_t'({1'b0, opc[3:0]}) :
               opc[4:0] == 5'd0 ? S_JN  :
               opc[4:0] == 5'd1 ? S_JNN :
               opc[4:0] == 5'd2 ? S_JNC :
               opc[4:0] == 5'd3 ? S_AND :
               opc[4:0] == 5'd4 ? S_OR  :
               opc[4:0] == 5'd5 ? S_XOR : S_ILL;
   end
   // next state and flag capture
   always_comb begin
      state_d = state_q;
      flg_d   = alu_st ? {N, Z, C} : flg_q;
      case (state_q)
         S_RESET:              state_d = S_FETCH;
         S_FETCH:              state_d = rdy ? S_DECODE : S_FETCH;
         S_DECODE:             state_d = dec;
         S_LOAD, S_STO, S_LDI: state_d = rdy ? S_FETCH : state_q;
         S_HALT:               state_d = cont ? S_FETCH : S_HALT;
         S_ILL:                state_d = S_ILL;
         default:              state_d = S_FETCH;
      endcase
   end
   // state and flag registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RESET;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         flg_q   <= flg_d;
      end
   end
   // control word fields; memory strobes only fire once memory is ready
   always_comb begin
      w_adr   = '0;
      r_adr   = '0;
      s_adr   = '0;
      adr_sel = 1'b0;
      s_sel   = 1'b0;
      pc_inc  = 1'b0;
      ir_ld   = 1'b0;
      mw_en   = 1'b0;
      rw_en   = 1'b0;
      halted  = 1'b0;
      illegal = 1'b0;
      status  = {flg_q, state_q};
      case (state_q)
         S_RESET:  status = 8'hFF;
         S_FETCH:  begin status = 8'h80; ir_ld = rdy; pc_inc = rdy; end
         S_DECODE: status = 8'hC0;
         S_ILL:    begin status = 8'hF0; illegal = 1'b1; end
         S_ADD, S_SUB, S_AND, S_OR, S_XOR: begin w_adr = d; r_adr = a; s_adr = b; rw_en = 1'b1; end
         S_CMP:    begin r_adr = a; s_adr = b; end
         S_MOV:    begin w_adr = d; s_adr = b; adr_sel = 1'b1; rw_en = 1'b1; end
         S_SHL, S_SHR, S_INC, S_DEC: begin w_adr = d; s_adr = b; rw_en = 1'b1; end
         S_LOAD:   begin w_adr = d; r_adr = b; adr_sel = 1'b1; rw_en = rdy; end
         S_STO:    begin r_adr = d; s_adr = b; adr_sel = 1'b1; mw_en = rdy; end
         S_LDI:    begin w_adr = d; s_sel = 1'b1; rw_en = rdy; pc_inc = rdy; end
         S_HALT:   halted = 1'b1;
         default:  ;
      endcase
   end
   assign pc_sel = in_exec && !(state_q inside {S_LDI, S_HALT, S_JE, S_JNE, S_JC, S_JMP, S_JN, S_JNN, S_JNC});
   assign pc_ld  = (state_q == S_JE  &&  flg_q[1]) || (state_q == S_JNE && !flg_q[1]) ||
                   (state_q == S_JC  &&  flg_q[0]) || (state_q == S_JNC && !flg_q[0]) ||
                   (state_q == S_JN  &&  flg_q[2]) || (state_q == S_JNN && !flg_q[2]) ||
                   state_q == S_JMP;
   assign alu_op = ALU_W'(state_q == S_ADD ? 4'h4 :
                          state_q inside {S_SUB, S_CMP} ? 4'h5 :
                          state_q == S_AND ? 4'h8 :
                          state_q == S_OR  ? 4'h9 :
                          state_q == S_XOR ? 4'hA :
                          state_q == S_SHL ? 4'h7 :
                          state_q == S_SHR ? 4'h6 :
                          state_q == S_INC ? 4'h2 :
                          state_q == S_DEC ? 4'h3 : 4'h0);
endmodule
